// File: rtl/prefetcher_pkg.sv
// Shared types for the prefetcher queue front end:
// queue opcodes, queue error codes and the data width helper.
package prefetcher_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PREF    = 3'd1,
        OP_MASTER  = 3'd2,
        OP_DATA    = 3'd3,
        OP_PROMISE = 3'd4
    } q_op_e;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
    localparam logic [2:0] ERR_PROTOCOL  = 3'd4;

    function automatic int data_bits(input int log_bytes);
        return 8 << log_bytes;
    endfunction

endpackage

// File: rtl/pref_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head.
// Push while full and pop while empty are ignored.
module pref_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // pointers wrap naturally; occupancy tracks push/pop balance
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // storage needs no reset; occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/prefetcher_op_arbiter.sv
// Opcode sequencer in front of the prefetcher data queue.
// Define PREF_ARB_ERR_LOG_EN to build the sticky queue error log.
module prefetcher_op_arbiter
    import prefetcher_pkg::*;
#(
    parameter int ADDR_BITS            = 64,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int LOG_QUEUE_SIZE       = 8,
    parameter int LOG_R_FIFO_DEPTH     = 2,
    parameter int PF_MAX_OUTSTANDING   = 4,
    localparam int DATA_BITS = data_bits(LOG_BLOCK_DATA_BYTES)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [LOG_QUEUE_SIZE-1:0] burstLen,
    input  logic                      s_ar_valid,
    output logic                      s_ar_ready,
    input  logic [ADDR_BITS-1:0]      s_ar_addr,
    output logic                      s_r_valid,
    input  logic                      s_r_ready,
    output logic [DATA_BITS-1:0]      s_r_data,
    output logic                      s_r_last,
    input  logic                      pf_valid,
    output logic                      pf_ready,
    input  logic [ADDR_BITS-1:0]      pf_addr,
    output logic                      m_ar_valid,
    input  logic                      m_ar_ready,
    output logic [ADDR_BITS-1:0]      m_ar_addr,
    output logic [LOG_QUEUE_SIZE-1:0] m_ar_len,
    input  logic                      m_r_valid,
    output logic                      m_r_ready,
    input  logic [DATA_BITS-1:0]      m_r_data,
    input  logic                      m_r_last,
    output logic [2:0]                q_opcode,
    output logic [ADDR_BITS-1:0]      q_addr,
    output logic [DATA_BITS-1:0]      q_data,
    output logic                      q_last,
    input  logic                      q_addrHit,
    input  logic                      q_pr_r_valid,
    input  logic                      q_almostFull,
    input  logic [DATA_BITS-1:0]      q_respData,
    input  logic                      q_respLast,
    input  logic [LOG_QUEUE_SIZE:0]   q_prefetchReqCnt,
    input  logic [2:0]                q_errorCode,
    output logic [2:0]                err_sticky
);

    localparam int AR_W = ADDR_BITS + LOG_QUEUE_SIZE;
    localparam logic [LOG_QUEUE_SIZE:0] PF_MAX_CNT =
        (LOG_QUEUE_SIZE+1)'(PF_MAX_OUTSTANDING);

    q_op_e                 op;
    logic                  hold_valid;
    logic [ADDR_BITS-1:0]  hold_addr;
    logic                  promise;
    logic                  miss_room;
    logic                  pf_conflict;
    logic                  pf_ok;
    logic                  rf_full;
    logic                  rf_empty;
    logic [DATA_BITS:0]    rf_head;
    logic                  af_push;
    logic                  af_full;
    logic                  af_empty;
    logic [AR_W-1:0]       af_head;

    assign promise     = q_pr_r_valid && s_r_ready;
    assign miss_room   = !q_almostFull && !af_full;
    assign pf_conflict = hold_valid && (hold_addr == pf_addr);
    assign pf_ok       = pf_valid && miss_room && !pf_conflict
                      && (q_prefetchReqCnt < PF_MAX_CNT);

    // fixed priority: promise > data > master > prefetch > nop
    always_comb begin
        op = OP_NOP;
        if (promise)
            op = OP_PROMISE;
        else if (!rf_empty)
            op = OP_DATA;
        else if (hold_valid && (q_addrHit || miss_room))
            op = OP_MASTER;
        else if (pf_ok)
            op = OP_PREF;
    end

    // master AR holding register; frees when its opcode issues
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
        end else if (s_ar_valid && s_ar_ready) begin
            hold_valid <= 1'b1;
            hold_addr  <= s_ar_addr;
        end else if (op == OP_MASTER) begin
            hold_valid <= 1'b0;
        end
    end

    pref_sync_fifo #(
        .WIDTH     (DATA_BITS + 1),
        .LOG_DEPTH (LOG_R_FIFO_DEPTH)
    ) u_r_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .push      (m_r_valid && m_r_ready),
        .push_data ({m_r_last, m_r_data}),
        .pop       (op == OP_DATA),
        .head      (rf_head),
        .full      (rf_full),
        .empty     (rf_empty)
    );

    assign af_push = (op == OP_PREF)
                  || (op == OP_MASTER && !q_addrHit);

    pref_sync_fifo #(
        .WIDTH     (AR_W),
        .LOG_DEPTH (1)
    ) u_ar_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .push      (af_push),
        .push_data ({q_addr, burstLen}),
        .pop       (m_ar_ready),
        .head      (af_head),
        .full      (af_full),
        .empty     (af_empty)
    );

    assign q_opcode   = op;
    assign q_addr     = hold_valid ? hold_addr : pf_addr;
    assign {q_last, q_data} = rf_head;
    assign m_r_ready  = !rf_full;
    assign m_ar_valid = !af_empty;
    assign {m_ar_addr, m_ar_len} = af_head;
    assign s_ar_ready = !hold_valid;
    assign pf_ready   = (op == OP_PREF);
    assign s_r_valid  = q_pr_r_valid;
    assign s_r_data   = q_respData;
    assign s_r_last   = q_respLast;

`ifdef PREF_ARB_ERR_LOG_EN
    logic [2:0] err_q;
    logic [7:0] err_cnt;

    // keep the first error code and count error events
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            err_q   <= ERR_NONE;
            err_cnt <= '0;
        end else if (q_errorCode != ERR_NONE) begin
            if (err_q == ERR_NONE)
                err_q <= q_errorCode;
            if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_sticky = err_q;
`else
    logic [2:0] unused_err;
    assign unused_err = q_errorCode;
    assign err_sticky = ERR_NONE;
`endif

endmodule

// File: tb/tb_prefetcher_op_arbiter.sv
// Bench for prefetcher_op_arbiter: scripted vectors,
// corner sequences and a queue-based random reference model.
module tb_prefetcher_op_arbiter;
    import prefetcher_pkg::*;

    localparam int DB = data_bits(6);

`ifdef PREF_ARB_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN;
    logic [7:0]    burstLen;
    logic          s_ar_valid, s_ar_ready;
    logic [63:0]   s_ar_addr;
    logic          s_r_valid, s_r_ready;
    logic [DB-1:0] s_r_data;
    logic          s_r_last;
    logic          pf_valid, pf_ready;
    logic [63:0]   pf_addr;
    logic          m_ar_valid, m_ar_ready;
    logic [63:0]   m_ar_addr;
    logic [7:0]    m_ar_len;
    logic          m_r_valid, m_r_ready;
    logic [DB-1:0] m_r_data;
    logic          m_r_last;
    logic [2:0]    q_opcode;
    logic [63:0]   q_addr;
    logic [DB-1:0] q_data;
    logic          q_last;
    logic          q_addrHit, q_pr_r_valid, q_almostFull;
    logic [DB-1:0] q_respData;
    logic          q_respLast;
    logic [8:0]    q_prefetchReqCnt;
    logic [2:0]    q_errorCode;
    logic [2:0]    err_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prefetcher_op_arbiter dut (
        .clk              (clk),
        .resetN           (resetN),
        .burstLen         (burstLen),
        .s_ar_valid       (s_ar_valid),
        .s_ar_ready       (s_ar_ready),
        .s_ar_addr        (s_ar_addr),
        .s_r_valid        (s_r_valid),
        .s_r_ready        (s_r_ready),
        .s_r_data         (s_r_data),
        .s_r_last         (s_r_last),
        .pf_valid         (pf_valid),
        .pf_ready         (pf_ready),
        .pf_addr          (pf_addr),
        .m_ar_valid       (m_ar_valid),
        .m_ar_ready       (m_ar_ready),
        .m_ar_addr        (m_ar_addr),
        .m_ar_len         (m_ar_len),
        .m_r_valid        (m_r_valid),
        .m_r_ready        (m_r_ready),
        .m_r_data         (m_r_data),
        .m_r_last         (m_r_last),
        .q_opcode         (q_opcode),
        .q_addr           (q_addr),
        .q_data           (q_data),
        .q_last           (q_last),
        .q_addrHit        (q_addrHit),
        .q_pr_r_valid     (q_pr_r_valid),
        .q_almostFull     (q_almostFull),
        .q_respData       (q_respData),
        .q_respLast       (q_respLast),
        .q_prefetchReqCnt (q_prefetchReqCnt),
        .q_errorCode      (q_errorCode),
        .err_sticky       (err_sticky)
    );

    typedef struct {
        int     arv;
        longint araddr;
        int     pfv;
        longint pfaddr;
        int     mrv;
        int     mrl;
        int     hit;
        int     af;
        int     cnt;
        int     prv;
        int     srr;
        int     marr;
        int     op;
        int     arr;
        int     pfr;
        int     mrr;
        int     marv;
        longint maraddr;
    } vec_t;

    vec_t tbl [23];

    // reference model state
    logic [DB:0]  rq [$];
    logic [71:0]  aq [$];
    logic [63:0]  hq [$];
    int           e_op;
    bit           e_mrr, e_arr, pconf;
    logic [63:0]  cand;

    task automatic chk(input string nm,
                       input logic [DB-1:0] act,
                       input logic [DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        s_ar_valid = 0; s_ar_addr = '0;
        s_r_ready = 0; pf_valid = 0; pf_addr = '0;
        m_ar_ready = 0; m_r_valid = 0;
        m_r_data = '0; m_r_last = 0;
        q_addrHit = 0; q_pr_r_valid = 0;
        q_almostFull = 0; q_respData = '0;
        q_respLast = 0; q_prefetchReqCnt = '0;
        q_errorCode = ERR_NONE;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        resetN = 0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1;
    endtask

    initial begin
        // arv addr pfv pfaddr mrv mrl hit af cnt prv srr marr
        //   | op arr pfr mrr marv maraddr
        tbl[0]  = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,1,0,0};
        tbl[1]  = '{1,'h1000,0,0,0,0,0,0,0,0,0,0, 0,1,0,1,0,0};
        tbl[2]  = '{0,0,0,0,0,0,0,0,0,0,0,0, 2,0,0,1,0,0};
        tbl[3]  = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,1,1,'h1000};
        tbl[4]  = '{1,'h2000,0,0,0,0,0,0,0,0,0,1, 0,1,0,1,1,'h1000};
        tbl[5]  = '{0,0,0,0,0,0,1,0,0,0,0,0, 2,0,0,1,0,0};
        tbl[6]  = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,1,0,0};
        tbl[7]  = '{0,0,1,'h3000,0,0,0,0,4,0,0,0, 0,1,0,1,0,0};
        tbl[8]  = '{0,0,1,'h3000,0,0,0,0,3,0,0,0, 1,1,1,1,0,0};
        tbl[9]  = '{0,0,0,0,0,0,0,0,0,0,0,1, 0,1,0,1,1,'h3000};
        tbl[10] = '{0,0,0,0,1,0,0,0,0,0,0,0, 0,1,0,1,0,0};
        tbl[11] = '{0,0,0,0,0,0,0,0,0,1,1,0, 4,1,0,1,0,0};
        tbl[12] = '{0,0,0,0,0,0,0,0,0,0,0,0, 3,1,0,1,0,0};
        tbl[13] = '{1,'h4000,0,0,0,0,0,0,0,0,0,0, 0,1,0,1,0,0};
        tbl[14] = '{0,0,0,0,0,0,0,1,0,0,0,0, 0,0,0,1,0,0};
        tbl[15] = '{0,0,0,0,0,0,1,1,0,0,0,0, 2,0,0,1,0,0};
        tbl[16] = '{0,0,1,'h5000,0,0,0,1,0,0,0,0, 0,1,0,1,0,0};
        tbl[17] = '{0,0,1,'h5000,0,0,0,0,0,0,0,0, 1,1,1,1,0,0};
        tbl[18] = '{0,0,1,'h6000,0,0,0,0,0,0,0,0, 1,1,1,1,1,'h5000};
        tbl[19] = '{0,0,1,'h7000,0,0,0,0,0,0,0,0, 0,1,0,1,1,'h5000};
        tbl[20] = '{0,0,0,0,0,0,0,0,0,0,0,1, 0,1,0,1,1,'h5000};
        tbl[21] = '{0,0,0,0,0,0,0,0,0,0,0,1, 0,1,0,1,1,'h6000};
        tbl[22] = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,1,0,0};

        burstLen = 8'd3;
        do_reset();
        chk("rst_err", err_sticky, 0);

        foreach (tbl[i]) begin
            s_ar_valid = 1'(tbl[i].arv);
            s_ar_addr  = 64'(tbl[i].araddr);
            pf_valid   = 1'(tbl[i].pfv);
            pf_addr    = 64'(tbl[i].pfaddr);
            m_r_valid  = 1'(tbl[i].mrv);
            m_r_last   = 1'(tbl[i].mrl);
            m_r_data   = DB'(i);
            q_addrHit  = 1'(tbl[i].hit);
            q_almostFull = 1'(tbl[i].af);
            q_prefetchReqCnt = 9'(tbl[i].cnt);
            q_pr_r_valid = 1'(tbl[i].prv);
            s_r_ready  = 1'(tbl[i].srr);
            m_ar_ready = 1'(tbl[i].marr);
            @(negedge clk);
            chk("vec_op", q_opcode, DB'(tbl[i].op));
            chk("vec_ar_ready", s_ar_ready, DB'(tbl[i].arr));
            chk("vec_pf_ready", pf_ready, DB'(tbl[i].pfr));
            chk("vec_m_r_ready", m_r_ready, DB'(tbl[i].mrr));
            chk("vec_m_ar_valid", m_ar_valid, DB'(tbl[i].marv));
            chk("vec_s_r_valid", s_r_valid, DB'(tbl[i].prv));
            if (tbl[i].marv != 0) begin
                chk("vec_m_ar_addr", m_ar_addr, DB'(tbl[i].maraddr));
                chk("vec_m_ar_len", m_ar_len, 3);
            end
            if (tbl[i].op == 3)
                chk("vec_q_data", q_data, 10);
            step();
        end

        // R buffer fills while promises hold the slot
        do_reset();
        q_pr_r_valid = 1;
        s_r_ready = 1;
        for (int b = 0; b < 5; b++) begin
            m_r_valid = 1;
            m_r_data  = DB'(b + 'hA0);
            m_r_last  = (b == 3);
            @(negedge clk);
            chk("rbuf_fill_ready", m_r_ready, DB'(b < 4));
            chk("rbuf_fill_op", q_opcode, 4);
            step();
        end
        m_r_valid = 0;
        q_pr_r_valid = 0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("rbuf_drain_op", q_opcode, 3);
            chk("rbuf_drain_data", q_data, DB'(b + 'hA0));
            chk("rbuf_drain_last", q_last, DB'(b == 3));
            chk("rbuf_drain_ready", m_r_ready, DB'(b != 0));
            step();
        end
        @(negedge clk);
        chk("rbuf_empty_op", q_opcode, 0);
        step();

        // async reset discards buffered beats and requests
        do_reset();
        pf_valid = 1;
        pf_addr = 64'h9000;
        s_ar_valid = 1;
        s_ar_addr = 64'h8000;
        step();
        idle();
        q_pr_r_valid = 1;
        s_r_ready = 1;
        m_r_valid = 1;
        m_r_data = DB'(7);
        step();
        idle();
        @(negedge clk);
        chk("pre_rst_op", q_opcode, 3);
        chk("pre_rst_m_ar_valid", m_ar_valid, 1);
        chk("pre_rst_ar_ready", s_ar_ready, 0);
        #2;
        resetN = 0;
        #1;
        chk("in_rst_op", q_opcode, 0);
        chk("in_rst_m_ar_valid", m_ar_valid, 0);
        chk("in_rst_ar_ready", s_ar_ready, 1);
        chk("in_rst_m_r_ready", m_r_ready, 1);
        chk("in_rst_pf_ready", pf_ready, 0);
        step();
        resetN = 1;
        @(negedge clk);
        chk("post_rst_op", q_opcode, 0);
        chk("post_rst_m_ar_valid", m_ar_valid, 0);
        step();

        // sticky error capture
        q_errorCode = ERR_UNDERFLOW;
        step();
        q_errorCode = ERR_PROTOCOL;
        @(negedge clk);
        chk("err_first", err_sticky, LOG_EN ? 2 : 0);
        step();
        q_errorCode = ERR_NONE;
        @(negedge clk);
        chk("err_hold", err_sticky, LOG_EN ? 2 : 0);
        do_reset();
        @(negedge clk);
        chk("err_cleared", err_sticky, 0);
        step();

        // randomized traffic against a queue model
        idle();
        resetN = 0;
        burstLen = 8'($urandom_range(0, 255));
        repeat (2) @(posedge clk);
        #1;
        resetN = 1;
        rq.delete();
        aq.delete();
        hq.delete();
        for (int c = 0; c < 3000; c++) begin
            s_ar_valid = 1'($urandom_range(0, 1));
            s_ar_addr  = 64'h100 * $urandom_range(1, 4);
            pf_valid   = 1'($urandom_range(0, 1));
            pf_addr    = 64'h100 * $urandom_range(1, 4);
            m_r_valid  = 1'($urandom_range(0, 1));
            m_r_data   = {16{$urandom()}};
            m_r_last   = 1'($urandom_range(0, 1));
            q_addrHit  = 1'($urandom_range(0, 1));
            q_almostFull = ($urandom_range(0, 3) == 0);
            q_prefetchReqCnt = 9'($urandom_range(0, 6));
            q_pr_r_valid = ($urandom_range(0, 2) == 0);
            s_r_ready  = 1'($urandom_range(0, 1));
            m_ar_ready = 1'($urandom_range(0, 1));
            q_respData = {16{$urandom()}};
            q_respLast = 1'($urandom_range(0, 1));
            @(negedge clk);

            e_mrr = rq.size() < 4;
            e_arr = hq.size() == 0;
            cand  = (hq.size() > 0) ? hq[0] : pf_addr;
            pconf = (hq.size() > 0) && (hq[0] == pf_addr);
            if (q_pr_r_valid && s_r_ready)
                e_op = 4;
            else if (rq.size() > 0)
                e_op = 3;
            else if (hq.size() > 0 && (q_addrHit
                     || (!q_almostFull && aq.size() < 2)))
                e_op = 2;
            else if (pf_valid && !q_almostFull && !pconf
                     && q_prefetchReqCnt < 4 && aq.size() < 2)
                e_op = 1;
            else
                e_op = 0;

            chk("rnd_op", q_opcode, DB'(e_op));
            chk("rnd_pf_ready", pf_ready, DB'(e_op == 1));
            chk("rnd_ar_ready", s_ar_ready, DB'(e_arr));
            chk("rnd_m_r_ready", m_r_ready, DB'(e_mrr));
            chk("rnd_q_addr", q_addr, DB'(cand));
            chk("rnd_s_r_valid", s_r_valid, DB'(q_pr_r_valid));
            chk("rnd_s_r_data", s_r_data, q_respData);
            chk("rnd_m_ar_valid", m_ar_valid, DB'(aq.size() > 0));
            if (aq.size() > 0) begin
                chk("rnd_m_ar_addr", m_ar_addr, DB'(aq[0][71:8]));
                chk("rnd_m_ar_len", m_ar_len, DB'(aq[0][7:0]));
            end
            if (e_op == 3) begin
                chk("rnd_q_data", q_data, rq[0][DB-1:0]);
                chk("rnd_q_last", q_last, DB'(rq[0][DB]));
            end

            if (m_ar_ready && aq.size() > 0)
                void'(aq.pop_front());
            if (e_op == 3)
                void'(rq.pop_front());
            if (e_op == 2) begin
                if (!q_addrHit)
                    aq.push_back({hq[0], burstLen});
                void'(hq.pop_front());
            end
            if (e_op == 1)
                aq.push_back({pf_addr, burstLen});
            if (m_r_valid && e_mrr)
                rq.push_back({m_r_last, m_r_data});
            if (s_ar_valid && e_arr)
                hq.push_back(s_ar_addr);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
